// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if -- byte-wide instruction memory read port | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface if_fetch_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_byte_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_byte_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_byte_i
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- assembles 32-bit LE instructions from a byte port | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_fetch (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc_i,
  input  logic         ex_b_flag_i,
  input  logic         stall_i,
  if_fetch_if.master   mem,
  output logic         stall_req_o,
  output logic         inst_valid_o,
  output logic [31:0]  inst_o,
  output logic [31:0]  inst_pc_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] base_q;
  logic [2:0]  issue_cnt_q;
  logic [2:0]  recv_cnt_q;
  logic        rd_pend_q;
  logic [23:0] buf_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_valid_q;
  logic        req_w;

  // A taken branch suppresses the request in the same cycle it is seen.
  assign req_w          = (state_q == S_FETCH) && (issue_cnt_q < 3'd4) && !ex_b_flag_i;
  assign mem.mem_req_o  = req_w;
  assign mem.mem_addr_o = base_q + {29'd0, issue_cnt_q};
  assign stall_req_o    = !((state_q == S_VALID) && !stall_i);

  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      base_q       <= 32'd0;
      issue_cnt_q  <= 3'd0;
      recv_cnt_q   <= 3'd0;
      rd_pend_q    <= 1'b0;
      buf_q        <= 24'd0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_valid_q <= 1'b0;
    end else if (ex_b_flag_i) begin
      state_q      <= S_FLUSH;
      inst_valid_q <= 1'b0;
      issue_cnt_q  <= 3'd0;
      recv_cnt_q   <= 3'd0;
      rd_pend_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          base_q      <= pc_i;
          issue_cnt_q <= 3'd0;
          recv_cnt_q  <= 3'd0;
          rd_pend_q   <= 1'b0;
          state_q     <= S_FETCH;
        end
        S_FETCH: begin
          rd_pend_q <= req_w && mem.mem_gnt_i;
          if (req_w && mem.mem_gnt_i) begin
            issue_cnt_q <= issue_cnt_q + 3'd1;
          end
          if (rd_pend_q) begin
            recv_cnt_q <= recv_cnt_q + 3'd1;
            case (recv_cnt_q)
              3'd0:    buf_q[7:0]   <= mem.mem_byte_i;
              3'd1:    buf_q[15:8]  <= mem.mem_byte_i;
              3'd2:    buf_q[23:16] <= mem.mem_byte_i;
              default: begin
                // Fourth byte goes straight into the delivered word.
                inst_q       <= {mem.mem_byte_i, buf_q};
                inst_pc_q    <= base_q;
                inst_valid_q <= 1'b1;
                state_q      <= S_VALID;
              end
            endcase
          end
        end
        S_VALID: begin
          if (!stall_i) begin
            inst_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        S_FLUSH: begin
          rd_pend_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- directed + random bench for if_fetch against a timing model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ex_b_flag_i;
  logic        stall_i;
  logic        stall_req_o;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  always #5 clk = ~clk;

  if_fetch_if mem_if();

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .ex_b_flag_i  (ex_b_flag_i),
    .stall_i      (stall_i),
    .mem          (mem_if),
    .stall_req_o  (stall_req_o),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: mode 0 idle, 1 fetching, 2 holding result, 3 flush.
  int          m_mode;
  int          m_ng;
  logic [31:0] m_base;
  logic [31:0] pc_reg;
  logic        pend;
  logic [7:0]  next_byte;
  int          adv_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mem_at(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_at(a + 32'd3), mem_at(a + 32'd2), mem_at(a + 32'd1), mem_at(a)};
  endfunction

  task automatic reset_checks();
    check_eq("rst_req",       32'(mem_if.mem_req_o), 32'd0);
    check_eq("rst_addr",      mem_if.mem_addr_o,     32'd0);
    check_eq("rst_valid",     32'(inst_valid_o),     32'd0);
    check_eq("rst_inst",      inst_o,                32'd0);
    check_eq("rst_inst_pc",   inst_pc_o,             32'd0);
    check_eq("rst_stall_req", 32'(stall_req_o),      32'd1);
  endtask

  task automatic model_reset(input logic [31:0] new_pc);
    m_mode = 0;
    m_ng   = 0;
    m_base = 32'd0;
    pend   = 1'b0;
    pc_reg = new_pc;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic cycle(input logic br, input logic st, input logic g, input logic [31:0] tgt);
    logic e_req;
    logic e_stall;
    mem_if.mem_byte_i = pend ? next_byte : 8'($urandom);
    ex_b_flag_i       = br;
    stall_i           = st;
    mem_if.mem_gnt_i  = g;
    pc_i              = pc_reg;
    #1;
    e_req   = !br && (m_mode == 1) && (m_ng < 4);
    e_stall = !((m_mode == 2) && !st);
    check_eq("mem_req",    32'(mem_if.mem_req_o), 32'(e_req));
    if (e_req) check_eq("mem_addr", mem_if.mem_addr_o, m_base + 32'(m_ng));
    check_eq("stall_req",  32'(stall_req_o),  32'(e_stall));
    check_eq("inst_valid", 32'(inst_valid_o), 32'(m_mode == 2));
    if (m_mode == 2) begin
      check_eq("inst",    inst_o,    word_at(m_base));
      check_eq("inst_pc", inst_pc_o, m_base);
    end
    if (!stall_req_o) adv_cnt++;
    pend      = mem_if.mem_req_o && g;
    next_byte = mem_at(mem_if.mem_addr_o);
    if (br) begin
      m_mode = 3;
      m_ng   = 0;
    end else begin
      case (m_mode)
        0: begin m_base = pc_reg; m_ng = 0; m_mode = 1; end
        1: begin
          if (m_ng == 4) m_mode = 2;
          else if (e_req && g) m_ng++;
        end
        2: if (!st) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
    if (br) pc_reg = tgt;
    else if (!e_stall) pc_reg = pc_reg + 32'd4;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to_valid(input string tag);
    for (int i = 0; i < 40 && m_mode != 2; i++) cycle(1'b0, 1'b0, 1'b1, 32'd0);
    check_eq(tag, 32'(inst_valid_o), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    rst = 1'b0; pc_i = 32'd0; ex_b_flag_i = 1'b0; stall_i = 1'b0;
    mem_if.mem_gnt_i = 1'b0; mem_if.mem_byte_i = 8'd0;
    next_byte = 8'd0; adv_cnt = 0;
    model_reset(32'd0);
    @(negedge clk); #1;
    reset_checks();
    @(negedge clk);
    rst = 1'b1;

    // First fetch at 0x0, valid in cycle 6, then back-to-back at 0x4.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 32'd0);
    check_eq("t1_valid", 32'(inst_valid_o), 32'd1);
    check_eq("t1_inst",  inst_o, 32'h00100513);
    check_eq("t1_adv_before", 32'(adv_cnt), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'd0);
    check_eq("t1_adv", 32'(adv_cnt), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 32'd0);
    check_eq("t2_valid", 32'(inst_valid_o), 32'd1);
    check_eq("t2_pc",    inst_pc_o, 32'd4);
    cycle(1'b0, 1'b0, 1'b1, 32'd0);
    check_eq("t2_adv", 32'(adv_cnt), 32'd2);

    // Grant withheld three cycles on byte 2 at 0x100.
    cycle(1'b1, 1'b0, 1'b1, 32'h100);
    low = 0;
    for (int i = 0; i < 40 && m_mode != 2; i++) begin
      logic g;
      g = !((m_mode == 1) && (m_ng == 2) && (low < 3));
      if (!g) low++;
      cycle(1'b0, 1'b0, g, 32'd0);
    end
    check_eq("t3_valid", 32'(inst_valid_o), 32'd1);
    check_eq("t3_pc",    inst_pc_o, 32'h100);
    cycle(1'b0, 1'b0, 1'b1, 32'd0);

    // Downstream stall for four cycles while holding.
    run_to_valid("t4_valid");
    adv_cnt = 0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 32'd0);
    check_eq("t4_adv_held", 32'(adv_cnt), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'd0);
    check_eq("t4_adv", 32'(adv_cnt), 32'd1);

    // Branch after byte 1 of a fetch at 0x20, target 0x80.
    cycle(1'b1, 1'b0, 1'b1, 32'h20);
    for (int i = 0; i < 20 && !(m_mode == 1 && m_ng == 2); i++) cycle(1'b0, 1'b0, 1'b1, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 32'h80);
    cycle(1'b0, 1'b0, 1'b1, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'd0);
    check_eq("t5_req",  32'(mem_if.mem_req_o), 32'd1);
    check_eq("t5_addr", mem_if.mem_addr_o, 32'h80);
    run_to_valid("t5_valid");
    check_eq("t5_pc", inst_pc_o, 32'h80);
    cycle(1'b0, 1'b0, 1'b1, 32'd0);

    // Address wrap across the top of memory.
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    run_to_valid("wrap_valid");
    check_eq("wrap_inst", inst_o, word_at(32'hFFFF_FFFE));
    cycle(1'b0, 1'b0, 1'b1, 32'd0);

    // Asynchronous reset in the middle of a fetch at 0xFFFFFFFE.
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 20 && !(m_mode == 1 && m_ng == 2); i++) cycle(1'b0, 1'b0, 1'b1, 32'd0);
    #2 rst = 1'b0;
    #1;
    reset_checks();
    model_reset(32'h40);
    pc_i = 32'h40;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_to_valid("t6_valid");
    check_eq("t6_pc", inst_pc_o, 32'h40);
    cycle(1'b0, 1'b0, 1'b1, 32'd0);

    // Randomized traffic: grant gaps, stalls, branches at any time.
    for (int i = 0; i < 500; i++) begin
      logic        br;
      logic        st;
      logic        g;
      logic [31:0] tgt;
      br  = ($urandom_range(0, 99) < 3);
      st  = ($urandom_range(0, 2) == 0);
      g   = ($urandom_range(0, 3) != 0);
      tgt = $urandom;
      cycle(br, st, g, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch front end that consumes the program counter and returns whole instructions. It reads 32-bit instructions little-endian over a byte-wide memory read port and holds the PC register via a stall request until the instruction is delivered. It delivers the instruction, with its PC, to the IF/ID pipeline register. It discards in-flight work when EX signals a taken branch.

## Interface
- No parameters; address/data widths fixed at 32 bits; memory port 8 bits.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc_i`  in  32  current PC from the PC register.
- `ex_b_flag_i`  in  1  taken branch/jump resolved in EX; flush.
- `stall_i`  in  1  downstream (ID) cannot accept; hold delivered instruction.
- `mem_req_o`  out  1  byte read request.
- `mem_addr_o`  out  32  byte address of request.
- `mem_gnt_i`  in  1  request accepted this cycle.
- `mem_byte_i`  in  8  read data; valid the cycle after a granted request.
- `stall_req_o`  out  1  drives PC register stall bit 0; high = hold PC.
- `inst_valid_o`  out  1  `inst_o`/`inst_pc_o` valid.
- `inst_o`  out  32  assembled instruction.
- `inst_pc_o`  out  32  address of `inst_o`.

## Operation
- States: IDLE, FETCH, VALID, FLUSH. Registers: `base` (32), `issue_cnt` (0..4), `recv_cnt` (0..4), `rd_pend` (1), `buf` (32).
- IDLE: capture `base <= pc_i`, clear counters, go FETCH. No request in IDLE.
- FETCH: `mem_req_o = (issue_cnt < 4)`, `mem_addr_o = base + issue_cnt` (32-bit wrap). On `mem_req_o & mem_gnt_i`: `issue_cnt++`, `rd_pend <= 1`; else `rd_pend <= 0`. Address and request held stable while `mem_gnt_i` is low.
- Each cycle with `rd_pend`: `buf[8*recv_cnt +: 8] <= mem_byte_i`, `recv_cnt++`. Byte k of the instruction lands in bits [8k+7:8k].
- When the fourth byte is captured: `inst_o <= {byte, buf[23:0]}`, `inst_pc_o <= base`, `inst_valid_o <= 1`, go VALID.
- VALID: outputs held. If `stall_i` = 0, go IDLE and drop `inst_valid_o` next cycle. If `stall_i` = 1, remain.
- `stall_req_o` is combinational: 0 only when state = VALID and `stall_i` = 0. Otherwise 1 (including IDLE, FETCH, FLUSH). The PC therefore advances exactly once per delivered instruction.
- `ex_b_flag_i` = 1, any state, has priority over everything:
  - next state FLUSH;
  - `inst_valid_o <= 0`;
  - counters cleared;
  - `mem_req_o` forced 0 that cycle.
- FLUSH lasts one cycle: any response arriving then is discarded (`rd_pend` ignored and cleared). Then go IDLE, which captures the branch target already loaded into `pc_i`.
- `ex_b_flag_i` in FLUSH or IDLE re-enters FLUSH (restarts flush).
- Reset values: state IDLE; `mem_req_o` 0; `mem_addr_o` 0; `inst_valid_o` 0; `inst_o` 0; `inst_pc_o` 0; counters, `rd_pend`, `buf` 0. While `rst` is low, `stall_req_o` = 1.
- Reset asserted mid-fetch aborts immediately. Partial bytes are lost, and the first fetch after release uses `pc_i` in IDLE.

## Timing
- Fetch with `mem_gnt_i` always high, starting IDLE at cycle 0:
  - requests issued cycles 1–4;
  - data captured cycles 2–5;
  - `inst_valid_o` high from cycle 6;
  - `stall_req_o` low cycle 6 if `stall_i` = 0;
  - PC updates at end of cycle 6; IDLE cycle 7.
- Throughput: one instruction per 7 cycles with no wait states.
- Each cycle of `mem_gnt_i` low adds one cycle of latency.
- Taken branch at cycle t: FLUSH at t+1, IDLE captures target at t+2, first request at t+3.
- `inst_valid_o` is registered. `mem_req_o`, `mem_addr_o` and `stall_req_o` are combinational from state and inputs.

## Test plan
- Reset then `pc_i` = 0x0, memory bytes 0x13,0x05,0x10,0x00, gnt always 1 -> `inst_o` = 0x00100513, `inst_pc_o` = 0x0, valid at cycle 6, `stall_req_o` low exactly that cycle.
- Two back-to-back fetches at 0x0 and 0x4 -> addresses 0,1,2,3 then 4,5,6,7. Second valid 7 cycles after first, PC advanced once.
- `mem_gnt_i` low for 3 cycles on byte 2 at 0x100 -> `mem_addr_o` held at 0x102 all 3 cycles, valid delayed 3 cycles, assembled word correct.
- `stall_i` high for 4 cycles while VALID -> `inst_o`/`inst_pc_o` stable, `stall_req_o` = 1 throughout, single PC advance on release.
- `ex_b_flag_i` pulse after byte 1 of fetch at 0x20, target 0x80 -> no valid for 0x20. Pending byte discarded, next request at 0x80 two cycles after the flush cycle.
- `rst` low mid-fetch at 0xFFFFFFFE -> all outputs to reset values immediately. After release, fetch restarts cleanly. Separately check that address wrap gives 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
